dma_dreq_agent: RTL and testbench
=================================

Name: dma_dreq_agent

Overview:
- Peripheral-side end of the DREQ/DACK/EOP handshake served by the KF8237 controller; one instance per DMA-capable device channel.
- Buffers device bytes in a FIFO and raises DREQ according to a programmed request mode.
- Delivers one byte per acknowledged I/O read strobe and honours terminal count (EOP) from the controller.
- Covers device-to-memory (8237 "write transfer") only.

Parameters:
DEPTH, 16, FIFO depth in bytes; power of 2, at least 4.
THRESHOLD, 4, FIFO level (1..DEPTH) that triggers a request.

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  request generation enable
mode  input  2  00 single, 01 demand, 10 block, 11 reserved (treated as single)
dreq_active_low  input  1  DREQ output polarity select
push_valid  input  1  device byte strobe
push_data  input  8  device byte
push_ready  output  1  FIFO not full
dreq  output  1  DMA request to controller (polarity per dreq_active_low)
dack  input  1  DMA acknowledge, active-high internal form
io_read  input  1  one-cycle read strobe, qualified by dack
eop_in  input  1  terminal count / EOP from controller, active-high
data_out  output  8  byte presented to the bus
eop_out  output  1  device-generated EOP (optional feature)
level  output  $clog2(DEPTH)+1  FIFO occupancy
tc_done  output  1  sticky: transfer terminated by EOP
underflow  output  1  sticky: read strobe with empty FIFO

Behaviour:
- Reset values:
  - dreq = dreq_active_low (inactive level).
  - push_ready=1, data_out=8'h00, eop_out=0, level=0, tc_done=0, underflow=0.
  - State IDLE, FIFO empty.
- FIFO:
  - A push is accepted when push_valid && push_ready.
  - A pop occurs when io_read && dack && level!=0.
  - Simultaneous push and pop leave level unchanged; push on full is dropped.
  - Pointers wrap modulo DEPTH.
- data_out is registered: the popped byte appears the cycle after io_read and holds until the next pop.
- Read with empty FIFO (io_read && dack && level==0):
  - data_out=8'hFF, underflow set.
  - underflow clears only on reset or on the rising edge of enable.
- States:
  - IDLE -> REQ when enable && !tc_done && level>=THRESHOLD.
  - REQ: dreq active; -> ACTIVE when dack=1.
  - ACTIVE, single mode: after the first pop -> RELEASE.
  - ACTIVE, demand mode: stay while level>1 or no pop has occurred; on the pop that empties the FIFO -> RELEASE.
  - ACTIVE, block mode: hold DREQ through an empty FIFO (underflow possible); leave only on EOP.
  - ACTIVE, any mode: dack falling before the exit condition -> REQ (controller preempted).
  - RELEASE: dreq inactive for exactly one cycle -> IDLE.
  - DONE: entered from any state on eop_in && dack. Sets tc_done, dreq inactive. Left only on the rising edge of enable, which clears tc_done -> IDLE.
- dreq is registered: asserted/deasserted on the cycle after the state transition.
  - In single mode dreq drops in the cycle after the pop, giving the 8237 at least one inactive sample before re-request.
- enable falling:
  - In REQ -> IDLE next cycle.
  - In ACTIVE, finish any strobe in that cycle, then -> IDLE.
  - FIFO contents are retained.
- reserved mode 11 behaves as single.
- eop_in without dack is ignored.

Optional Feature:
- Macro DMA_DREQ_AGENT_EOP_GEN_EN.
- When defined, the block adds a 16-bit length input and a load_length input.
  - load_length (one cycle) loads a remaining-byte counter.
  - Each pop decrements the counter.
  - The pop that takes it from 1 to 0 drives eop_out=1 in that same cycle (combinational from io_read && dack) and enters DONE, setting tc_done.
  - Counter at 0: no eop_out generated.
- When undefined, eop_out is tied to 0 and there is no counter logic.

Test Plan:
- Single mode, THRESHOLD=4: push 4 bytes 11,22,33,44 -> dreq asserts 1 cycle later; dack+io_read -> data_out=11 next cycle, dreq drops; re-asserts only when level>=4.
- Demand mode: push 6 bytes, dack held, 6 io_read strobes -> data_out 6 bytes in order, level 0, dreq drops after 6th pop, 1-cycle release.
- Block mode: push 4, dack held, 5 io_read strobes -> 5th returns FF, underflow=1, dreq stays active until eop_in.
- eop_in with dack on 2nd byte in demand mode -> tc_done=1, dreq inactive; re-request blocked until enable toggles 0->1.
- dreq_active_low=1: reset -> dreq=1; request -> dreq=0; async reset mid-ACTIVE -> dreq=1, level=0 immediately.
- EOP_GEN_EN: load length=3, push 8, demand mode -> eop_out pulses with 3rd io_read, tc_done=1, level=5.

Source files
------------

// File: rtl/dma_dreq_agent.sv
// dma_dreq_agent: peripheral side of the 8237 DREQ/DACK/EOP handshake with a byte FIFO.
// Optional macro DMA_DREQ_AGENT_EOP_GEN_EN adds a length counter that raises eop_out.
module dma_dreq_agent #(
  parameter int DEPTH = 16,
  parameter int THRESHOLD = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic                   dreq_active_low,
  input  logic                   push_valid,
  input  logic [7:0]             push_data,
  output logic                   push_ready,
  output logic                   dreq,
  input  logic                   dack,
  input  logic                   io_read,
  input  logic                   eop_in,
  output logic [7:0]             data_out,
  output logic                   eop_out,
  output logic [$clog2(DEPTH):0] level,
  output logic                   tc_done,
  output logic                   underflow
`ifdef DMA_DREQ_AGENT_EOP_GEN_EN
  ,
  input  logic [15:0]            length,
  input  logic                   load_length
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, REQ, ACTIVE, RELEASE, DONE} state_t;
  state_t state, state_n;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic enable_q, dreq_r, en_rise, push, rd, pop, last_pop, gen_eop, eop, demand, block;
  assign en_rise = enable && !enable_q;
  assign push_ready = level != (AW+1)'(DEPTH);
  assign push = push_valid && push_ready;
  assign rd = io_read && dack;
  assign pop = rd && level != '0;
  assign last_pop = pop && !push && level == (AW+1)'(1);
  assign eop = dack && (eop_in || gen_eop);
  assign demand = mode == 2'b01;
  assign block = mode == 2'b10;
  assign tc_done = state == DONE;
  assign dreq = dreq_r ^ dreq_active_low;
`ifdef DMA_DREQ_AGENT_EOP_GEN_EN
  logic [15:0] remaining;
  assign gen_eop = pop && remaining == 16'd1;
  assign eop_out = gen_eop;
  always_ff @(posedge clock or posedge reset)
    if (reset)
      remaining <= '0;
    else if (load_length)
      remaining <= length;
    else if (pop && remaining != '0)
      remaining <= remaining - 16'd1;
`else
  assign gen_eop = 1'b0;
  assign eop_out = 1'b0;
`endif
  // REQ with dack already counts as ACTIVE, so a strobe in the grant cycle can end a single transfer
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = (enable && level >= (AW+1)'(THRESHOLD)) ? REQ : IDLE;
      REQ, ACTIVE: state_n = !enable ? IDLE : !dack ? REQ : block ? ACTIVE : (demand ? last_pop : pop) ? RELEASE : ACTIVE;
      RELEASE: state_n = IDLE;
      DONE: state_n = en_rise ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
    if (eop) state_n = DONE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      dreq_r <= 1'b0;
      enable_q <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      data_out <= 8'h00;
      underflow <= 1'b0;
    end else begin
      state <= state_n;
      dreq_r <= state_n == REQ || state_n == ACTIVE;
      enable_q <= enable;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      if (pop)
        data_out <= mem[rd_ptr];
      else if (rd)
        data_out <= 8'hFF;
      underflow <= (rd && !pop) || (underflow && !en_rise);
    end
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= push_data;
endmodule

// File: tb/tb_dma_dreq_agent.sv
// tb_dma_dreq_agent: directed bench with a queue-based reference model of dma_dreq_agent.
module tb_dma_dreq_agent;
  localparam int DEPTH = 16;
  logic clock = 0, reset = 1, enable = 0, dreq_active_low = 0, push_valid = 0, dack = 0, io_read = 0, eop_in = 0;
  logic [1:0] mode = 2'b00;
  logic [7:0] push_data = 8'h00;
  logic push_ready, dreq, eop_out, tc_done, underflow;
  logic [7:0] data_out;
  logic [4:0] level;
`ifdef DMA_DREQ_AGENT_EOP_GEN_EN
  logic [15:0] length = 16'd0;
  logic load_length = 0;
`endif
  int n_cmp = 0, n_bad = 0;
  byte unsigned q[$];
  logic [7:0] m_dout;
  bit m_unf, m_tc, m_en_prev;
  int m_cnt;

  dma_dreq_agent #(.DEPTH(DEPTH), .THRESHOLD(4)) dut (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode), .dreq_active_low(dreq_active_low),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready), .dreq(dreq),
    .dack(dack), .io_read(io_read), .eop_in(eop_in), .data_out(data_out), .eop_out(eop_out),
    .level(level), .tc_done(tc_done), .underflow(underflow)
`ifdef DMA_DREQ_AGENT_EOP_GEN_EN
    , .length(length), .load_length(load_length)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic req(input string name, input bit on);
    chk(name, dreq, on ^ dreq_active_low);
  endtask

  task automatic m_reset();
    q.delete();
    m_dout = 8'h00;
    m_unf = 0;
    m_tc = 0;
    m_en_prev = 0;
    m_cnt = 0;
  endtask

  task automatic m_update();
    bit rise, pok, pop, gen;
    rise = enable && !m_en_prev;
    m_en_prev = enable;
    pok = push_valid && q.size() < DEPTH;
    pop = io_read && dack && q.size() > 0;
    gen = 0;
`ifdef DMA_DREQ_AGENT_EOP_GEN_EN
    gen = pop && m_cnt == 1;
    if (load_length) m_cnt = int'(length);
    else if (pop && m_cnt > 0) m_cnt--;
`endif
    if (rise) m_unf = 0;
    if (pop) m_dout = q.pop_front();
    else if (io_read && dack) begin
      m_dout = 8'hFF;
      m_unf = 1;
    end
    if (pok) q.push_back(push_data);
    if (dack && (eop_in || gen)) m_tc = 1;
    else if (rise) m_tc = 0;
  endtask

  task automatic step();
    @(posedge clock);
    if (!reset) m_update();
    @(negedge clock);
  endtask

  task automatic do_reset();
    push_valid = 0; dack = 0; io_read = 0; eop_in = 0;
    reset = 1;
    m_reset();
    step();
    reset = 0;
  endtask

  task automatic push_n(input logic [7:0] first, input logic [7:0] inc, input int n);
    logic [7:0] b;
    b = first;
    for (int i = 0; i < n; i++) begin
      push_valid = 1;
      push_data = b;
      step();
      b = b + inc;
    end
    push_valid = 0;
  endtask

  initial forever begin
    @(posedge clock);
    #2;
    chk("level", level, q.size());
    chk("push_ready", push_ready, q.size() < DEPTH);
    chk("data_out", data_out, m_dout);
    chk("underflow", underflow, m_unf);
    chk("tc_done", tc_done, m_tc);
  end

  initial begin
    m_reset();
    step();
    step();
    req("rst_dreq", 0);
    chk("rst_push_ready", push_ready, 1);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_eop_out", eop_out, 0);
    chk("rst_level", level, 0);
    chk("rst_tc", tc_done, 0);
    chk("rst_unf", underflow, 0);
    reset = 0;
    enable = 1;
    // single mode
    push_n(8'h11, 8'h11, 4);
    req("t1_idle", 0);
    step();
    req("t1_req", 1);
    dack = 1; io_read = 1;
    step();
    chk("t1_data", data_out, 8'h11);
    chk("t1_level", level, 3);
    req("t1_drop", 0);
    dack = 0; io_read = 0;
    step();
    req("t1_release", 0);
    push_n(8'h55, 8'h00, 1);
    req("t1_wait", 0);
    step();
    req("t1_rereq", 1);
    // demand mode
    do_reset();
    mode = 2'b01;
    push_n(8'hA1, 8'h01, 6);
    step();
    req("t2_req", 1);
    dack = 1; io_read = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) chk("t2_first", data_out, 8'hA1);
      req($sformatf("t2_pop%0d", i), i < 5);
    end
    chk("t2_last", data_out, 8'hA6);
    chk("t2_level", level, 0);
    dack = 0; io_read = 0;
    step();
    req("t2_release", 0);
    // block mode
    do_reset();
    mode = 2'b10;
    push_n(8'hB1, 8'h01, 4);
    step();
    req("t3_req", 1);
    dack = 1; io_read = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      req($sformatf("t3_pop%0d", i), 1);
    end
    chk("t3_ff", data_out, 8'hFF);
    chk("t3_unf", underflow, 1);
    io_read = 0;
    step();
    req("t3_hold", 1);
    eop_in = 1;
    step();
    chk("t3_tc", tc_done, 1);
    req("t3_eop", 0);
    eop_in = 0; dack = 0;
    step();
    req("t3_done", 0);
    enable = 0;
    step();
    chk("t3_tc_hold", tc_done, 1);
    enable = 1;
    step();
    chk("t3_tc_clr", tc_done, 0);
    chk("t3_unf_clr", underflow, 0);
    // EOP mid demand transfer
    do_reset();
    mode = 2'b01;
    push_n(8'hC1, 8'h01, 6);
    step();
    req("t4_req", 1);
    dack = 1; io_read = 1;
    step();
    chk("t4_d1", data_out, 8'hC1);
    eop_in = 1;
    step();
    chk("t4_d2", data_out, 8'hC2);
    chk("t4_tc", tc_done, 1);
    chk("t4_level", level, 4);
    req("t4_off", 0);
    io_read = 0; eop_in = 0; dack = 0;
    step();
    step();
    req("t4_blocked", 0);
    enable = 0;
    step();
    enable = 1;
    step();
    chk("t4_tc_clr", tc_done, 0);
    req("t4_idle", 0);
    step();
    req("t4_rereq", 1);
    eop_in = 1;
    step();
    chk("t4_eop_nodack", tc_done, 0);
    req("t4_still_req", 1);
    eop_in = 0; enable = 0;
    step();
    req("t4_en_fall", 0);
    chk("t4_retained", level, 4);
    enable = 1;
    // full FIFO
    do_reset();
    enable = 0;
    push_n(8'h00, 8'h01, 17);
    chk("t5_full", level, 16);
    chk("t5_not_ready", push_ready, 0);
    push_valid = 1; push_data = 8'h99; dack = 1; io_read = 1;
    step();
    chk("t5_pop_full", level, 15);
    chk("t5_data", data_out, 8'h00);
    push_valid = 0; dack = 0; io_read = 0;
    enable = 1;
    // active-low DREQ and async reset
    dreq_active_low = 1;
    reset = 1;
    m_reset();
    #1;
    chk("t6_rst_dreq", dreq, 1);
    step();
    reset = 0;
    mode = 2'b00;
    push_n(8'hE0, 8'h01, 4);
    step();
    chk("t6_req_low", dreq, 0);
    dack = 1;
    step();
    chk("t6_active_low", dreq, 0);
    #2;
    reset = 1;
    m_reset();
    #1;
    chk("t6_async_dreq", dreq, 1);
    chk("t6_async_level", level, 0);
    dack = 0;
    step();
    reset = 0;
    dreq_active_low = 0;
`ifdef DMA_DREQ_AGENT_EOP_GEN_EN
    do_reset();
    mode = 2'b01;
    length = 16'd3; load_length = 1;
    step();
    load_length = 0;
    push_n(8'hD1, 8'h01, 8);
    step();
    req("t7_req", 1);
    dack = 1; io_read = 1;
    #1;
    chk("t7_eop_early", eop_out, 0);
    step();
    step();
    #1;
    chk("t7_eop_pulse", eop_out, 1);
    step();
    chk("t7_tc", tc_done, 1);
    chk("t7_level", level, 5);
    req("t7_off", 0);
    dack = 0; io_read = 0;
    #1;
    chk("t7_eop_end", eop_out, 0);
`endif
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
